// File: rtl/instr_loader.sv
// instr_loader: boot-time program loader sitting in front of the pipelined CPU.
// Assembles a little-endian byte stream into WIDTH-bit words, writes them to
// instruction memory at addresses 0..INSTRACTION_NUMBERS-1 and keeps the CPU in
// reset until the whole program has been written.
// Optional build macro LOADER_CHECKSUM_EN: adds a trailing checksum byte and an
// ERROR state. Without it, DONE follows the final write and error is tied low.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start, CPU held in reset
// RECV  | accepting bytes of the current word (byte_ready=1)
// WRITE | one-cycle memory write of the assembled word
// CHECK | accepting the single checksum byte (checksum build only)
// DONE  | program loaded, CPU released, only rst leaves
// ERROR | checksum mismatch, CPU held in reset (checksum build only)

module instr_loader #(
   parameter  int WIDTH               = 32,
   parameter  int INSTRACTION_NUMBERS = 8,
   localparam int AW                  = (INSTRACTION_NUMBERS > 1) ? $clog2(INSTRACTION_NUMBERS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       byte_data,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic             imem_we,
   output logic [AW-1:0]    imem_addr,
   output logic [WIDTH-1:0] imem_wdata,
   output logic             cpu_rst,
   output logic             busy,
   output logic             done,
   output logic             error
);

   localparam int BYTES = WIDTH / 8;
   localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

   localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
   localparam logic [AW-1:0]  LAST_WORD = AW'(INSTRACTION_NUMBERS - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RECV  = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef LOADER_CHECKSUM_EN
   localparam logic [2:0] ST_CHECK = 3'd4;
   localparam logic [2:0] ST_ERROR = 3'd5;
   localparam logic [2:0] ST_FINAL = ST_CHECK;
`else
   localparam logic [2:0] ST_FINAL = ST_DONE;
`endif

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [BCW-1:0]   byte_cnt;
   logic [AW-1:0]    word_cnt;
   logic [WIDTH-1:0] asm_word;
   logic [WIDTH-1:0] asm_nxt;
   logic             accept;
   logic             last_byte;
   logic             last_word;
   logic             restart;
   logic             ready_nxt;
   logic             busy_nxt;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]       sum;
   logic [7:0]       sum_nxt;
`endif

   assign accept    = byte_valid && byte_ready;
   assign last_byte = (byte_cnt == LAST_BYTE);
   assign last_word = (word_cnt == LAST_WORD);

`ifdef LOADER_CHECKSUM_EN
   assign restart = start && ((state == ST_IDLE) || (state == ST_ERROR));
   assign sum_nxt = sum + byte_data;
`else
   assign restart = start && (state == ST_IDLE);
`endif

   // Drop the incoming byte into its little-endian lane of the word being built.
   always_comb begin
      asm_nxt = asm_word;
      for (int i = 0; i < BYTES; i++) begin
         if (byte_cnt == BCW'(i)) begin
            asm_nxt[8*i +: 8] = byte_data;
         end
      end
   end

   // Next-state decision and the registered-output values that follow from it.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_RECV;
            end
         end
         ST_RECV: begin
            if (accept && last_byte) begin
               state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (last_word) begin
               state_nxt = ST_FINAL;
            end else begin
               state_nxt = ST_RECV;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (accept) begin
               state_nxt = (sum_nxt == 8'h00) ? ST_DONE : ST_ERROR;
            end
         end
         ST_ERROR: begin
            if (start) begin
               state_nxt = ST_RECV;
            end
         end
`endif
         ST_DONE: begin
            state_nxt = ST_DONE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      ready_nxt = (state_nxt == ST_RECV);
`ifdef LOADER_CHECKSUM_EN
      ready_nxt = ready_nxt || (state_nxt == ST_CHECK);
`endif
      busy_nxt  = ready_nxt || (state_nxt == ST_WRITE);
   end

   // State register and the status/handshake outputs, all registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         cpu_rst    <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         byte_ready <= ready_nxt;
         imem_we    <= (state_nxt == ST_WRITE);
         cpu_rst    <= (state_nxt != ST_DONE);
         busy       <= busy_nxt;
         done       <= (state_nxt == ST_DONE);
      end
   end

   // Byte/word counters, word assembly and the memory write address/data.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt   <= '0;
         word_cnt   <= '0;
         asm_word   <= '0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else if (restart) begin
         byte_cnt <= '0;
         word_cnt <= '0;
         asm_word <= '0;
      end else if ((state == ST_RECV) && accept) begin
         asm_word <= asm_nxt;
         if (last_byte) begin
            byte_cnt   <= '0;
            imem_addr  <= word_cnt;
            imem_wdata <= asm_nxt;
         end else begin
            byte_cnt <= byte_cnt + BCW'(1);
         end
      end else if ((state == ST_WRITE) && !last_word) begin
         word_cnt <= word_cnt + AW'(1);
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // Running modulo-256 sum over every data byte plus the checksum byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum <= 8'h00;
      end else if (restart) begin
         sum <= 8'h00;
      end else if (((state == ST_RECV) || (state == ST_CHECK)) && accept) begin
         sum <= sum_nxt;
      end
   end

   // Error flag follows the ERROR state; a restart clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         error <= 1'b0;
      end else begin
         error <= (state_nxt == ST_ERROR);
      end
   end
`else
   assign error = 1'b0;
`endif

endmodule
